add_4bit_seq_ctrl: RTL and testbench



---
 rtl/add_4bit_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_add_4bit_seq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/add_4bit_seq_ctrl.sv
// add_4bit_seq_ctrl: WIDTH-bit adder built from one time-shared 4-bit adder.
// Each nibble takes two adder passes (operands, then the running carry), so
// latency is fixed at 2*NIB+1 cycles from the accepted start to done_out.

// Plain nibble adder with carry-out and no carry-in.
module add_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [3:0] o_sum,
    output logic       o_carry
);
    logic [4:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum   = w_full[3:0];
    assign o_carry = w_full[4];
endmodule

module add_4bit_seq_ctrl #(
    parameter int WIDTH = 16   // multiple of 4, at least 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_INC, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDXW-1:0]  r_idx;
    logic [3:0]       r_psum;
    logic             r_c1;
    logic             r_creg;
    logic [WIDTH-1:0] r_wsum;

    logic [3:0]       w_add_a;
    logic [3:0]       w_add_b;
    logic [3:0]       w_add_sum;
    logic             w_add_carry;
    logic [WIDTH-1:0] w_wsum_upd;
    logic             w_last;

    assign w_last = (r_idx == LAST_IDX);

    // The single shared nibble adder; its inputs come only from the FSM mux.
    add_4bit u_add (
        .i_a     (w_add_a),
        .i_b     (w_add_b),
        .o_sum   (w_add_sum),
        .o_carry (w_add_carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; the INC pass always runs so latency is data-independent.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_in) w_next = S_ADD;
            S_ADD:   w_next = S_INC;
            S_INC:   w_next = w_last ? S_DONE : S_ADD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode and adder input mux.
    always_comb begin
        busy_out = (r_state != S_IDLE);
        done_out = (r_state == S_DONE);
        w_add_a  = 4'h0;
        w_add_b  = 4'h0;
        case (r_state)
            S_ADD: begin
                w_add_a = r_a[{r_idx, 2'b00} +: 4];
                w_add_b = r_b[{r_idx, 2'b00} +: 4];
            end
            S_INC: begin
                w_add_a = r_psum;
                w_add_b = {3'b000, r_creg};
            end
            default: ;
        endcase
    end

    // Working result with the current INC nibble merged in; feeds sum_out on
    // the last INC so the result is already visible during DONE.
    always_comb begin
        w_wsum_upd = r_wsum;
        w_wsum_upd[{r_idx, 2'b00} +: 4] = w_add_sum;
    end

    // Datapath registers. c1 and the INC carry are mutually exclusive
    // (psum+1 can only carry when psum is 4'hF, which ADD cannot produce with
    // a carry), so OR-ing them gives the exact nibble carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_psum    <= '0;
            r_c1      <= 1'b0;
            r_creg    <= 1'b0;
            r_wsum    <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_a    <= a_in;
                        r_b    <= b_in;
                        r_idx  <= '0;
                        r_creg <= 1'b0;
                    end
                end
                S_ADD: begin
                    r_psum <= w_add_sum;
                    r_c1   <= w_add_carry;
                end
                S_INC: begin
                    r_wsum <= w_wsum_upd;
                    r_creg <= r_c1 | w_add_carry;
                    if (w_last) begin
                        sum_out   <= w_wsum_upd;
                        carry_out <= r_c1 | w_add_carry;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_add_4bit_seq_ctrl.sv
// Self-checking bench for add_4bit_seq_ctrl: a cycle-counting reference model
// of the requester-visible behaviour, a per-cycle compare process, and
// directed scenarios with hand-computed results.
module tb_add_4bit_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;
    localparam int LAT   = 2 * NIB + 1;   // cycle index of done after E0

    logic             clk = 1'b0;
    logic             rst;
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    add_4bit_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_in  (start_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_cnt counts cycles since the accepted start
    // (0 = idle); the true sum is taken at acceptance and published at LAT.
    int              m_cnt = 0;
    logic [WIDTH:0]  m_pend = '0;
    logic [WIDTH-1:0] m_sum = '0;
    logic            m_c = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0;
            m_sum <= '0;
            m_c   <= 1'b0;
        end else if (m_cnt == 0) begin
            if (start_in) begin
                m_cnt  <= 1;
                m_pend <= {1'b0, a_in} + {1'b0, b_in};
            end
        end else if (m_cnt == LAT) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == LAT - 1) {m_c, m_sum} <= m_pend;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",  {31'b0, busy_out},  {31'b0, m_cnt != 0});
            chk("done",  {31'b0, done_out},  {31'b0, m_cnt == LAT});
            chk("sum",   {16'b0, sum_out},   {16'b0, m_sum});
            chk("carry", {31'b0, carry_out}, {31'b0, m_c});
        end
    end

    // Launch a, b (E0 is the next edge), then run n cycles. In cycle c start
    // is pulsed if pmask[c] (with operands a2/b2), rst is pulsed at rst_cyc.
    // Reports first/last done cycle, done count and results seen at done.
    task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [31:0] pmask, input int rst_cyc, input int n,
                       input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2,
                       output int first_cyc, output int last_cyc, output int ndone,
                       output logic [WIDTH-1:0] first_sum, output logic first_c,
                       output logic [WIDTH-1:0] last_sum, output logic last_c);
        logic [31:0] m;
        m = pmask;
        first_cyc = 0; last_cyc = 0; ndone = 0;
        first_sum = '0; first_c = 1'b0; last_sum = '0; last_c = 1'b0;
        @(posedge clk); #1;
        start_in = 1'b1; a_in = a; b_in = b;
        @(posedge clk); #1;   // E0 has passed; now in cycle 1
        for (int c = 1; c <= n; c++) begin
            start_in = m[c];
            rst      = (c == rst_cyc);
            a_in     = m[c] ? a2 : WIDTH'($urandom);
            b_in     = m[c] ? b2 : WIDTH'($urandom);
            @(negedge clk);
            if (done_out) begin
                ndone++;
                if (ndone == 1) begin
                    first_cyc = c; first_sum = sum_out; first_c = carry_out;
                end
                last_cyc = c; last_sum = sum_out; last_c = carry_out;
            end
            @(posedge clk); #1;
        end
        start_in = 1'b0;
        rst      = 1'b0;
    endtask

    int fc, lc, nd;
    logic [WIDTH-1:0] fs, ls;
    logic fcar, lcar;

    task automatic simple(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] es, input logic ec);
        run(a, b, 32'h0, 0, 12, '0, '0, fc, lc, nd, fs, fcar, ls, lcar);
        chk({nm, "_ndone"}, nd, 1);
        chk({nm, "_cycle"}, fc, LAT);
        chk({nm, "_sum"},   {16'b0, fs}, {16'b0, es});
        chk({nm, "_carry"}, {31'b0, fcar}, {31'b0, ec});
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; a_in = '0; b_in = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy",  {31'b0, busy_out},  0);
        chk("rst_done",  {31'b0, done_out},  0);
        chk("rst_sum",   {16'b0, sum_out},   0);
        chk("rst_carry", {31'b0, carry_out}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        simple("t1234", 16'h1234, 16'h4321, 16'h5555, 1'b0);
        simple("tffff1", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        simple("t0f0f", 16'h0F0F, 16'h00F1, 16'h1000, 1'b0);
        simple("tffffff", 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);

        // Start pulses at cycles 3 and 9 (busy, including DONE) are ignored.
        run(16'h1111, 16'h2222, (32'h1 << 3) | (32'h1 << 9), 0, 14,
            16'hAAAA, 16'h5555, fc, lc, nd, fs, fcar, ls, lcar);
        chk("ign_ndone", nd, 1);
        chk("ign_cycle", fc, LAT);
        chk("ign_sum",   {16'b0, fs}, 32'h3333);
        chk("ign_carry", {31'b0, fcar}, 0);

        // Reset at cycle 4 aborts: no done, outputs cleared.
        run(16'h5555, 16'h5555, 32'h0, 4, 12, '0, '0, fc, lc, nd, fs, fcar, ls, lcar);
        chk("abort_ndone", nd, 0);
        @(negedge clk);
        chk("abort_sum",   {16'b0, sum_out}, 0);
        chk("abort_carry", {31'b0, carry_out}, 0);
        chk("abort_busy",  {31'b0, busy_out}, 0);
        simple("after_rst", 16'h0001, 16'h0002, 16'h0003, 1'b0);

        // Back-to-back: second start in cycle 10 completes at cycle 19.
        run(16'h8000, 16'h8000, 32'h1 << 10, 0, 22, 16'h0123, 16'h0456,
            fc, lc, nd, fs, fcar, ls, lcar);
        chk("b2b_ndone",  nd, 2);
        chk("b2b_first",  fc, LAT);
        chk("b2b_last",   lc, 19);
        chk("b2b_sum1",   {16'b0, fs}, 32'h0000);
        chk("b2b_c1",     {31'b0, fcar}, 1);
        chk("b2b_sum2",   {16'b0, ls}, 32'h0579);
        chk("b2b_c2",     {31'b0, lcar}, 0);

        // Randomized traffic: random starts, operands and occasional resets,
        // checked every cycle by the model compare.
        for (int i = 0; i < 1500; i++) begin
            start_in = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 59) == 0);
            a_in     = WIDTH'($urandom);
            b_in     = WIDTH'($urandom);
            @(posedge clk); #1;
        end
        // Held start: continuous restarts.
        rst = 1'b0; start_in = 1'b1;
        repeat (40) begin
            a_in = WIDTH'($urandom);
            b_in = WIDTH'($urandom);
            @(posedge clk); #1;
        end
        start_in = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
